pixel_write_buffer: RTL and testbench

- Sits directly downstream of the game view pixel mux.
- Accepts its per-cycle pixel stream (X, Y, 12-bit colour, write strobe), discards off-screen pixels, and buffers the rest in a FIFO.
- Drains the FIFO into the framebuffer memory port as linear address plus data, with a valid/ready handshake.
- Provides a flush handshake so the view FSM knows when a whole frame's pixels have landed in memory.

---
 rtl/pixel_write_buffer.sv | 128 ++++++++++++
 tb/tb_pixel_write_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// rtl/pixel_write_buffer.sv - on-screen pixel FIFO draining into the framebuffer write port
// Off-screen pixels are counted and discarded; a flush handshake reports when memory has caught up.
module pixel_write_buffer #(
   parameter int DEPTH        = 16,
   parameter int SCREEN_W     = 320,
   parameter int SCREEN_H     = 240,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [8:0]             X_in,
   input  logic [7:0]             Y_in,
   input  logic [11:0]            Color_in,
   input  logic                   writeEn_in,
   input  logic                   flush_req,
   output logic [16:0]            fb_addr,
   output logic [11:0]            fb_data,
   output logic                   fb_we,
   input  logic                   fb_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   almost_full,
   output logic                   overflow,
   output logic [7:0]             oob_count,
   output logic                   flush_done
);
   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C     = (AW+1)'(DEPTH);
   localparam logic [AW:0] AFULL_C    = (AW+1)'(DEPTH - AFULL_MARGIN);
   localparam logic [8:0]  SCREEN_W_C = 9'(SCREEN_W);
   localparam logic [7:0]  SCREEN_H_C = 8'(SCREEN_H);

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

   logic [28:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [16:0]   fb_addr_q, fb_addr_d;
   logic [11:0]   fb_data_q, fb_data_d;
   logic          fb_we_q, fb_we_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    oob_count_q, oob_count_d;
   state_t        state_q, state_d;
   logic          in_range, push, pop;
   logic [16:0]   pix_addr;

   always_comb begin
      in_range = (X_in < SCREEN_W_C) && (Y_in < SCREEN_H_C);
      push     = writeEn_in && in_range && (count_q != FULL_C);
      pop      = (!fb_we_q || fb_ready) && (count_q != '0);
      // Y*320 + X without a multiplier
      pix_addr = {1'b0, Y_in, 8'b0} + {3'b0, Y_in, 6'b0} + {8'b0, X_in};
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      fb_addr_d   = fb_addr_q;
      fb_data_d   = fb_data_q;
      fb_we_d     = fb_we_q;
      overflow_d  = overflow_q;
      oob_count_d = oob_count_q;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      if (pop) begin
         fb_we_d   = 1'b1;
         fb_addr_d = mem[rd_ptr_q][28:12];
         fb_data_d = mem[rd_ptr_q][11:0];
      end else if (fb_ready) begin
         fb_we_d   = 1'b0;
      end
      if (writeEn_in && in_range && (count_q == FULL_C)) overflow_d = 1'b1;
      if (writeEn_in && !in_range && (oob_count_q != 8'hFF)) oob_count_d = oob_count_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (flush_req) state_d = DRAIN;
         // a pixel landing on this edge still has to drain first
         DRAIN:   if ((count_q == '0) && !fb_we_q && !push) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {pix_addr, Color_in};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fb_addr_q   <= '0;
         fb_data_q   <= '0;
         fb_we_q     <= 1'b0;
         overflow_q  <= 1'b0;
         oob_count_q <= '0;
         state_q     <= IDLE;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fb_addr_q   <= fb_addr_d;
         fb_data_q   <= fb_data_d;
         fb_we_q     <= fb_we_d;
         overflow_q  <= overflow_d;
         oob_count_q <= oob_count_d;
         state_q     <= state_d;
      end
   end

   assign fb_addr     = fb_addr_q;
   assign fb_data     = fb_data_q;
   assign fb_we       = fb_we_q;
   assign count       = count_q;
   assign almost_full = (count_q >= AFULL_C);
   assign overflow    = overflow_q;
   assign oob_count   = oob_count_q;
   assign flush_done  = (state_q == DONE);
endmodule

// File: tb/tb_pixel_write_buffer.sv
// tb/tb_pixel_write_buffer.sv - directed checks of pixel_write_buffer
// Transfers are logged at the clock edge; all other observations are taken on the falling edge.
module tb_pixel_write_buffer;
   logic        clk = 1'b0;
   logic        resetn;
   logic [8:0]  X_in;
   logic [7:0]  Y_in;
   logic [11:0] Color_in;
   logic        writeEn_in;
   logic        flush_req;
   logic [16:0] fb_addr;
   logic [11:0] fb_data;
   logic        fb_we;
   logic        fb_ready;
   logic [4:0]  count;
   logic        almost_full;
   logic        overflow;
   logic [7:0]  oob_count;
   logic        flush_done;

   int total = 0;
   int bad   = 0;
   logic [28:0] wlog[$];

   pixel_write_buffer dut (
      .clk(clk), .resetn(resetn), .X_in(X_in), .Y_in(Y_in), .Color_in(Color_in),
      .writeEn_in(writeEn_in), .flush_req(flush_req), .fb_addr(fb_addr), .fb_data(fb_data),
      .fb_we(fb_we), .fb_ready(fb_ready), .count(count), .almost_full(almost_full),
      .overflow(overflow), .oob_count(oob_count), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (resetn && fb_we && fb_ready) wlog.push_back({fb_addr, fb_data});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pix(input int x, input int y, input int c);
      X_in       = 9'(x);
      Y_in       = 8'(y);
      Color_in   = 12'(c);
      writeEn_in = 1'b1;
   endtask

   initial begin
      int exp_cnt;
      int t_xfer;
      int t_done;
      int pulses;
      resetn = 1'b0; X_in = '0; Y_in = '0; Color_in = '0;
      writeEn_in = 1'b0; flush_req = 1'b0; fb_ready = 1'b0;
      step(); step();
      chk("rst_fb_we", 32'(fb_we), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_oob", 32'(oob_count), 0);
      chk("rst_flush_done", 32'(flush_done), 0);
      chk("rst_fb_addr", 32'(fb_addr), 0);
      resetn = 1'b1;
      step();

      // single pixel latency and address
      fb_ready = 1'b1;
      pix(5, 2, 12'hF00);
      step();
      writeEn_in = 1'b0;
      chk("t1_count_after_push", 32'(count), 1);
      chk("t1_we_after_push", 32'(fb_we), 0);
      step();
      chk("t1_we", 32'(fb_we), 1);
      chk("t1_addr", 32'(fb_addr), 645);
      chk("t1_data", 32'(fb_data), 32'hF00);
      step();
      chk("t1_we_drop", 32'(fb_we), 0);
      chk("t1_nwrites", 32'(wlog.size()), 1);

      // last on-screen pixel, then two off-screen ones
      pix(319, 239, 12'h0F0); step();
      pix(320, 10, 12'h123);  step();
      pix(10, 240, 12'h456);  step();
      writeEn_in = 1'b0;
      step(); step();
      chk("t2_nwrites", 32'(wlog.size()), 2);
      chk("t2_last_write", 32'(wlog[wlog.size()-1]), {3'b0, 17'd76799, 12'h0F0});
      chk("t2_oob", 32'(oob_count), 2);
      chk("t2_overflow", 32'(overflow), 0);

      // fill past capacity with the framebuffer stalled
      wlog.delete();
      fb_ready = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         pix(k - 1, 1, 12'h100 + k - 1);
         step();
         exp_cnt = (k == 1) ? 1 : ((k - 1 > 16) ? 16 : k - 1);
         chk($sformatf("t3_count_%0d", k), 32'(count), 32'(exp_cnt));
         chk($sformatf("t3_afull_%0d", k), 32'(almost_full), (exp_cnt >= 14) ? 1 : 0);
      end
      writeEn_in = 1'b0;
      chk("t3_overflow", 32'(overflow), 1);
      chk("t3_out_we", 32'(fb_we), 1);
      chk("t3_out_addr", 32'(fb_addr), 320);
      chk("t3_nwrites_stalled", 32'(wlog.size()), 0);
      fb_ready = 1'b1;
      for (int i = 0; i < 20; i++) step();
      chk("t3_nwrites", 32'(wlog.size()), 17);
      for (int i = 0; i < 17; i++) begin
         if (i < wlog.size())
            chk($sformatf("t3_order_%0d", i), 32'(wlog[i]), {3'b0, 17'(320 + i), 12'(12'h100 + i)});
      end
      chk("t3_empty_count", 32'(count), 0);
      chk("t3_empty_we", 32'(fb_we), 0);

      // stall in the middle of a burst
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         pix(20 + i, 3, 12'h200 + i);
         step();
      end
      writeEn_in = 1'b0;
      chk("t4_pre_addr", 32'(fb_addr), 982);
      fb_ready = 1'b0;
      step();
      chk("t4_hold1_addr", 32'(fb_addr), 982);
      chk("t4_hold1_data", 32'(fb_data), 32'h202);
      chk("t4_hold1_we", 32'(fb_we), 1);
      step();
      chk("t4_hold2_addr", 32'(fb_addr), 982);
      chk("t4_hold2_data", 32'(fb_data), 32'h202);
      fb_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      chk("t4_nwrites", 32'(wlog.size()), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < wlog.size())
            chk($sformatf("t4_order_%0d", i), 32'(wlog[i]), {3'b0, 17'(980 + i), 12'(12'h200 + i)});
      end

      // flush with pixels in flight
      wlog.delete();
      for (int i = 0; i < 4; i++) begin
         pix(i, 0, 12'h300 + i);
         step();
      end
      writeEn_in = 1'b0;
      flush_req  = 1'b1;
      step();
      flush_req  = 1'b0;
      chk("t5_no_early_done", 32'(flush_done), 0);
      t_xfer = -1; t_done = -1; pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (t_xfer < 0 && wlog.size() == 4) t_xfer = i;
         if (flush_done) begin
            pulses++;
            if (t_done < 0) t_done = i;
         end
      end
      chk("t5_xfer_seen", (t_xfer > 0) ? 1 : 0, 1);
      chk("t5_done_timing", 32'(t_done), 32'(t_xfer + 1));
      chk("t5_pulses", 32'(pulses), 1);

      // flush with everything already empty
      flush_req = 1'b1;
      step();
      flush_req = 1'b0;
      chk("t5e_done_e0", 32'(flush_done), 0);
      step();
      chk("t5e_done_e1", 32'(flush_done), 1);
      step();
      chk("t5e_done_e2", 32'(flush_done), 0);

      // asynchronous reset with data buffered
      wlog.delete();
      fb_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         pix(40 + i, 5, 12'h400 + i);
         step();
      end
      writeEn_in = 1'b0;
      chk("t6_pre_we", 32'(fb_we), 1);
      chk("t6_pre_count", 32'(count), 5);
      #2 resetn = 1'b0;
      #1;
      chk("t6_async_we", 32'(fb_we), 0);
      chk("t6_async_count", 32'(count), 0);
      chk("t6_async_overflow", 32'(overflow), 0);
      @(negedge clk);
      resetn   = 1'b1;
      fb_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("t6_no_writes", 32'(wlog.size()), 0);
      chk("t6_idle_we", 32'(fb_we), 0);
      pix(7, 7, 12'hABC);
      step();
      writeEn_in = 1'b0;
      step(); step();
      chk("t6_new_nwrites", 32'(wlog.size()), 1);
      if (wlog.size() > 0) chk("t6_new_write", 32'(wlog[0]), {3'b0, 17'd2247, 12'hABC});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
